instr_prefetch_queue: RTL and testbench

- Fetch-stage prefetch buffer that sits between the instruction RAM/delay path and the instruction register (IR) of the 3-stage pipeline.
- Autonomously issues sequential 8-bit-addressed reads, absorbs variable memory latency, and queues up to DEPTH 32-bit instructions, each tagged with its address.
- On a control-flow redirect it flushes, drops any in-flight response, and restarts at the new address.

---
 rtl/instr_prefetch_queue.sv | 145 ++++++++++++++
 tb/tb_instr_prefetch_queue.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_queue.sv
// Fetch-stage prefetch queue: sequential reads into a DEPTH-entry FIFO.
// Define PREFETCH_BYPASS_EN to forward a response straight to the IR when empty.
module instr_prefetch_queue #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int IW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic              mem_rdy,
  input  logic [DATA_W-1:0] mem_data,
  output logic              ir_valid,
  output logic [DATA_W-1:0] ir_data,
  output logic [ADDR_W-1:0] ir_pc,
  input  logic              ir_take,
  output logic [CW-1:0]     count
);

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    FULL,
    DISCARD
  } state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] addr_q;
  logic [IW-1:0]     wr_ptr;
  logic [IW-1:0]     rd_ptr;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [ADDR_W-1:0] pc_q [DEPTH];
  logic [DATA_W-1:0] hold_data;
  logic [ADDR_W-1:0] hold_pc;

  logic empty;
  logic rsp;
  logic pop;
  logic push;
  logic space;
  logic byp_hit;
  logic byp_take;

  assign empty = (count == '0);
  assign rsp   = (state == WAIT) && mem_rdy && !redirect;

`ifdef PREFETCH_BYPASS_EN
  assign byp_hit = rsp && empty;
`else
  assign byp_hit = 1'b0;
`endif

  assign byp_take = byp_hit && ir_take;
  assign pop      = ir_take && !empty && !redirect;
  assign push     = rsp && !byp_take;

  // A pop this cycle frees a slot for the read issued this cycle
  assign space    = (count < CW'(DEPTH)) || pop;
  assign mem_rd   = reset && !redirect && (state == REQ) && space;
  assign mem_addr = (state == REQ) ? fetch_pc : addr_q;

  always_comb begin
    ir_valid = !empty;
    ir_data  = empty ? hold_data : data_q[rd_ptr];
    ir_pc    = empty ? hold_pc : pc_q[rd_ptr];
    if (byp_hit) begin
      ir_valid = 1'b1;
      ir_data  = mem_data;
      ir_pc    = addr_q;
    end
  end

  always_comb begin
    state_nx = state;
    if (redirect) begin
      // A response landing with the redirect retires the outstanding read
      if ((state == WAIT || state == DISCARD) && !mem_rdy)
        state_nx = DISCARD;
      else
        state_nx = REQ;
    end else begin
      unique case (state)
        REQ:     state_nx = space ? WAIT : FULL;
        WAIT:    if (mem_rdy) state_nx = REQ;
        FULL:    if (count < CW'(DEPTH)) state_nx = REQ;
        DISCARD: if (mem_rdy) state_nx = REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= REQ;
      fetch_pc  <= '0;
      addr_q    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      hold_data <= '0;
      hold_pc   <= '0;
    end else begin
      state <= state_nx;
      if (mem_rd)
        addr_q <= fetch_pc;
      if (redirect) begin
        fetch_pc  <= redirect_addr;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        count     <= '0;
        hold_data <= '0;
        hold_pc   <= '0;
      end else begin
        if (rsp)
          fetch_pc <= fetch_pc + ADDR_W'(1);
        if (push)
          wr_ptr <= wr_ptr + IW'(1);
        if (pop)
          rd_ptr <= rd_ptr + IW'(1);
        count <= count + CW'(push) - CW'(pop);
        if (pop) begin
          hold_data <= data_q[rd_ptr];
          hold_pc   <= pc_q[rd_ptr];
        end else if (byp_take) begin
          hold_data <= mem_data;
          hold_pc   <= addr_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr] <= mem_data;
      pc_q[wr_ptr]   <= addr_q;
    end
  end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Bench for instr_prefetch_queue: latency-programmable memory model,
// scoreboard of issued reads, vector table of redirect runs, corner sequences.
module tb_instr_prefetch_queue;

  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

`ifdef PREFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          redirect;
  logic [AW-1:0] redirect_addr;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic          mem_rdy;
  logic [DW-1:0] mem_data;
  logic          ir_valid;
  logic [DW-1:0] ir_data;
  logic [AW-1:0] ir_pc;
  logic          ir_take;
  logic [CW-1:0] count;

  typedef struct {
    logic [AW-1:0] pc;
    logic [DW-1:0] data;
  } ent_t;

  typedef struct {
    logic [AW-1:0] tgt;
    int            lat;
    int            n;
    logic [AW-1:0] last;
  } vec_t;

  ent_t sb[$];
  int checks = 0;
  int failures = 0;
  int ntaken = 0;
  int mem_lat = 3;
  bit rst_toggle = 1'b0;
  logic [AW-1:0] exp_fetch = '0;
  logic [AW-1:0] last_pc = '0;

  instr_prefetch_queue #(
    .DATA_W(DW),
    .ADDR_W(AW),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .redirect(redirect),
    .redirect_addr(redirect_addr),
    .mem_addr(mem_addr),
    .mem_rd(mem_rd),
    .mem_rdy(mem_rdy),
    .mem_data(mem_data),
    .ir_valid(ir_valid),
    .ir_data(ir_data),
    .ir_pc(ir_pc),
    .ir_take(ir_take),
    .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] fdat(input logic [AW-1:0] a);
    return {a, ~a, a ^ 8'h5A, 8'hC3};
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Memory: answers each read mem_lat cycles after the strobe
  initial begin : mem_model
    int pend;
    logic [AW-1:0] pa;
    pend = 0;
    pa = '0;
    mem_rdy = 1'b0;
    mem_data = '0;
    forever begin
      @(posedge clk);
      if (!reset) begin
        pend = 0;
      end else if (mem_rd) begin
        chk("mem_addr", mem_addr, exp_fetch);
        chk("one_outstanding", pend, 0);
        sb.push_back('{exp_fetch, fdat(exp_fetch)});
        exp_fetch = exp_fetch + 8'd1;
        pa = mem_addr;
        pend = mem_lat;
      end
      #1;
      if (!reset) begin
        mem_rdy = rst_toggle ? ~mem_rdy : 1'b0;
        mem_data = '1;
      end else if (pend > 0) begin
        pend--;
        mem_rdy = (pend == 0);
        mem_data = (pend == 0) ? fdat(pa) : '0;
      end else begin
        mem_rdy = 1'b0;
      end
    end
  end

  task automatic cyc(input bit take, input bit rd, input logic [AW-1:0] ra);
    @(negedge clk);
    ir_take = take;
    redirect = rd;
    redirect_addr = ra;
    if (rd) begin
      sb.delete();
      exp_fetch = ra;
    end
    #1;
    if (ir_valid && ir_take && !redirect && reset) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_empty ir_pc=%0h expected=none", ir_pc);
      end else begin
        ent_t e;
        e = sb.pop_front();
        chk("ir_pc", ir_pc, e.pc);
        chk("ir_data", ir_data, e.data);
      end
      last_pc = ir_pc;
      ntaken++;
    end
  endtask

  task automatic run_until(input int target, input int budget, input string name);
    int i;
    i = 0;
    while (ntaken < target && i < budget) begin
      cyc(1'b1, 1'b0, '0);
      i++;
    end
    chk(name, ntaken >= target, 1);
  endtask

  initial begin
    vec_t vt[3];
    bit prev_rdy;
    bit hit;
    int n0;

    vt[0] = '{8'hFE, 3, 3, 8'h00};
    vt[1] = '{8'h7F, 1, 4, 8'h82};
    vt[2] = '{8'h10, 2, 2, 8'h11};

    reset = 1'b1;
    redirect = 1'b0;
    redirect_addr = '0;
    ir_take = 1'b0;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_ir_valid", ir_valid, 0);
    chk("rst_ir_data", ir_data, 0);
    chk("rst_ir_pc", ir_pc, 0);
    chk("rst_count", count, 0);

    // Sequential fetch, latency 3, consumer always ready
    @(negedge clk);
    reset = 1'b1;
    ir_take = 1'b1;
    #1;
    chk("rel_mem_rd", mem_rd, 1);
    prev_rdy = 1'b0;
    for (int i = 0; i < 40 && ntaken < 6; i++) begin
      cyc(1'b1, 1'b0, '0);
      if (mem_rdy) chk("valid_in_rdy_cycle", ir_valid, BYP);
      if (prev_rdy) chk("valid_after_rdy", ir_valid, !BYP);
      prev_rdy = mem_rdy;
    end
    chk("seq_taken", ntaken, 6);
    chk("seq_last_pc", last_pc, 8'h05);

    // Fill to FULL with no consumer, then one pop restarts fetch
    mem_lat = 1;
    cyc(1'b0, 1'b1, 8'h20);
    for (int i = 0; i < 30 && count != 3'd4; i++) cyc(1'b0, 1'b0, '0);
    chk("full_count", count, 4);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, '0);
      chk("full_no_rd", mem_rd, 0);
    end
    chk("full_head_pc", ir_pc, 8'h20);
    chk("full_head_data", ir_data, fdat(8'h20));
    cyc(1'b1, 1'b0, '0);
    for (int i = 0; i < 8 && !mem_rd; i++) cyc(1'b0, 1'b0, '0);
    chk("refill_rd", mem_rd, 1);
    chk("refill_addr", mem_addr, 8'h24);

    // Redirect vector table, including the FF->00 wrap
    foreach (vt[k]) begin
      mem_lat = vt[k].lat;
      cyc(1'b1, 1'b1, vt[k].tgt);
      n0 = ntaken;
      run_until(n0 + vt[k].n, 40, "tbl_progress");
      chk("tbl_last_pc", last_pc, vt[k].last);
    end

    // Redirect while waiting on address 5; its data arrives in DISCARD
    mem_lat = 3;
    cyc(1'b1, 1'b1, 8'h00);
    for (int i = 0; i < 60 && !(mem_rd && mem_addr == 8'h05); i++)
      cyc(1'b1, 1'b0, '0);
    chk("saw_rd5", mem_rd && mem_addr == 8'h05, 1);
    cyc(1'b1, 1'b1, 8'h40);
    for (int i = 0; i < 10 && !mem_rd; i++) cyc(1'b1, 1'b0, '0);
    chk("redir_rd_addr", mem_addr, 8'h40);
    n0 = ntaken;
    run_until(n0 + 1, 40, "redir_progress");
    chk("redir_first_pc", last_pc, 8'h40);

    // Redirect, mem_rdy and ir_take together with two entries queued
    mem_lat = 1;
    cyc(1'b0, 1'b1, 8'h60);
    cyc(1'b0, 1'b0, '0);
    hit = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (count == 3'd2 && mem_rdy) begin
        hit = 1'b1;
        break;
      end
    end
    chk("combo_setup", hit, 1);
    ir_take = 1'b1;
    redirect = 1'b1;
    redirect_addr = 8'h60;
    sb.delete();
    exp_fetch = 8'h60;
    cyc(1'b0, 1'b0, '0);
    chk("combo_count", count, 0);
    chk("combo_valid", ir_valid, 0);
    chk("combo_pc", ir_pc, 0);
    chk("combo_data", ir_data, 0);
    for (int i = 0; i < 10 && !mem_rd; i++) cyc(1'b0, 1'b0, '0);
    chk("combo_rd_addr", mem_addr, 8'h60);
    n0 = ntaken;
    run_until(n0 + 1, 20, "combo_progress");
    chk("combo_first_pc", last_pc, 8'h60);

    // Reset mid-WAIT with mem_rdy toggling during reset
    mem_lat = 3;
    cyc(1'b1, 1'b1, 8'h30);
    for (int i = 0; i < 10 && !mem_rd; i++) cyc(1'b1, 1'b0, '0);
    cyc(1'b1, 1'b0, '0);
    @(negedge clk);
    rst_toggle = 1'b1;
    reset = 1'b0;
    ir_take = 1'b0;
    sb.delete();
    exp_fetch = '0;
    #1;
    chk("mid_rst_mem_rd", mem_rd, 0);
    chk("mid_rst_mem_addr", mem_addr, 0);
    chk("mid_rst_valid", ir_valid, 0);
    chk("mid_rst_data", ir_data, 0);
    chk("mid_rst_pc", ir_pc, 0);
    chk("mid_rst_count", count, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("hold_rst_valid", ir_valid, 0);
    chk("hold_rst_count", count, 0);
    @(negedge clk);
    reset = 1'b1;
    rst_toggle = 1'b0;
    #1;
    chk("rerel_mem_rd", mem_rd, 1);
    chk("rerel_mem_addr", mem_addr, 0);
    n0 = ntaken;
    run_until(n0 + 2, 40, "rerel_progress");
    chk("rerel_last_pc", last_pc, 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
